// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU types and sizing helpers for the serial subtractor
package alu_pkg;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} sub_state_t;

  function automatic int nchunk(input int width, input int chunk);
    return width / chunk;
  endfunction

  // One spare bit so the counter can also represent NCHUNK itself
  function automatic int cnt_width(input int n);
    return $clog2(n) + 1;
  endfunction

  localparam int NCHUNK_DEFAULT = nchunk(32, 4);

endpackage

// File: rtl/sub_chunk.sv
// rtl/sub_chunk.sv - combinational W-bit ripple full-adder slice
module sub_chunk #(
  parameter int W = 4
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  input  logic         cin,
  output logic [W-1:0] s,
  output logic         cout
);

  logic [W:0] c;

  always_comb begin
    s    = '0;
    c    = '0;
    c[0] = cin;
    for (int i = 0; i < W; i++) begin
      s[i]   = x[i] ^ y[i] ^ c[i];
      c[i+1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
    end
  end

  assign cout = c[W];

endmodule

// File: rtl/sub_serial32.sv
// rtl/sub_serial32.sv - multi-cycle a - b, CHUNK bits per clock, LSB chunk first
// Reuses one sub_chunk slice; the carry lives in carry_q between chunks.
module sub_serial32
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             ovf,
  output logic             zero
);

  localparam int NCHUNK = nchunk(WIDTH, CHUNK);
  localparam int CNT_W  = cnt_width(NCHUNK);

  if ((CHUNK < 1) || ((WIDTH % CHUNK) != 0)) begin : g_bad_chunk
    $error("sub_serial32: WIDTH must be a positive multiple of CHUNK");
  end

  sub_state_t       state_q;
  logic [WIDTH-1:0] a_q, nb_q, res_q, diff_q;
  logic [WIDTH-1:0] a_d, nb_d, res_d;
  logic [CNT_W-1:0] cnt_q;
  logic             carry_q, a_msb_q, b_msb_q;
  logic             in_ready_q, out_valid_q, borrow_q, ovf_q, zero_q;
  logic [CHUNK-1:0] sum_s;
  logic             sum_c;
  logic             last_chunk;

  sub_chunk #(.W(CHUNK)) u_chunk (
    .x   (a_q[CHUNK-1:0]),
    .y   (nb_q[CHUNK-1:0]),
    .cin (carry_q),
    .s   (sum_s),
    .cout(sum_c)
  );

  // Operands drain toward bit 0; each sum slice enters the result at the top
  assign a_d        = a_q >> CHUNK;
  assign nb_d       = nb_q >> CHUNK;
  assign res_d      = (res_q >> CHUNK) | (WIDTH'(sum_s) << (WIDTH - CHUNK));
  assign last_chunk = (cnt_q == CNT_W'(NCHUNK - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      a_q         <= '0;
      nb_q        <= '0;
      res_q       <= '0;
      diff_q      <= '0;
      cnt_q       <= '0;
      carry_q     <= 1'b0;
      a_msb_q     <= 1'b0;
      b_msb_q     <= 1'b0;
      borrow_q    <= 1'b0;
      ovf_q       <= 1'b0;
      zero_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q        <= a;
            nb_q       <= ~b;
            carry_q    <= 1'b1;
            cnt_q      <= '0;
            a_msb_q    <= a[WIDTH-1];
            b_msb_q    <= b[WIDTH-1];
            in_ready_q <= 1'b0;
            state_q    <= BUSY;
          end
        end
        BUSY: begin
          a_q     <= a_d;
          nb_q    <= nb_d;
          res_q   <= res_d;
          carry_q <= sum_c;
          cnt_q   <= cnt_q + CNT_W'(1);
          if (last_chunk) begin
            diff_q      <= res_d;
            borrow_q    <= ~sum_c;
            ovf_q       <= (a_msb_q != b_msb_q) && (res_d[WIDTH-1] != a_msb_q);
            zero_q      <= ~|res_d;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q     <= IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign diff      = diff_q;
  assign borrow    = borrow_q;
  assign ovf       = ovf_q;
  assign zero      = zero_q;

endmodule
